// File: rtl/nios_hps_system_i2c_target.sv
// ============================================================================
// nios_hps_system_i2c_target
//   I2C target with a 4 x 8-bit register file, reachable over I2C (pointer
//   byte) and over an Avalon-MM slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nios_hps_system_i2c_target #(
    parameter logic [6:0] I2C_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WDATA    = 4'd5,
        ST_WACK     = 4'd6,
        ST_RDATA    = 4'd7,
        ST_RACK     = 4'd8,
        ST_WAIT     = 4'd9
    } state_t;

    // [0]/[1] synchroniser stages, [2] previous synchronised value for edge detect
    logic [2:0]  r_scl_sh;
    logic [2:0]  r_sda_sh;
    logic        w_scl;
    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nx;
    logic [3:0]  r_bitcnt;
    logic [3:0]  w_bitcnt_nx;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nx;
    logic        r_sda_oe;
    logic        w_sda_oe_nx;
    logic        w_i2c_we;
    logic [7:0]  w_byte;

    logic [7:0]  r_regs [4];
    logic [31:0] r_readdata;
    logic        r_irq;
    logic        w_av_we;
    logic        w_unused_wdata;

    assign w_scl      = r_scl_sh[1];
    assign w_sda      = r_sda_sh[1];
    assign w_scl_rise = r_scl_sh[1] & ~r_scl_sh[2];
    assign w_scl_fall = ~r_scl_sh[1] & r_scl_sh[2];
    assign w_start    = w_scl & r_scl_sh[2] & r_sda_sh[2] & ~w_sda;
    assign w_stop     = w_scl & r_scl_sh[2] & ~r_sda_sh[2] & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    assign w_av_we        = chipselect & ~write_n;
    assign w_unused_wdata = ^writedata[31:8];

    assign sda_oe   = r_sda_oe;
    assign readdata = r_readdata;
    assign irq      = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sh <= 3'b111;
            r_sda_sh <= 3'b111;
            r_state  <= ST_IDLE;
            r_shift  <= 8'h00;
            r_bitcnt <= 4'd0;
            r_ptr    <= 2'd0;
            r_sda_oe <= 1'b0;
        end else begin
            r_scl_sh <= {r_scl_sh[1:0], scl_in};
            r_sda_sh <= {r_sda_sh[1:0], sda_in};
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_ptr    <= w_ptr_nx;
            r_sda_oe <= w_sda_oe_nx;
        end
    end

    // ACK states are entered on the 8th SCL rise; r_sda_oe doubles as the
    // phase flag: first fall starts driving ACK, second fall ends the slot.
    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bitcnt_nx = r_bitcnt;
        w_ptr_nx    = r_ptr;
        w_sda_oe_nx = r_sda_oe;
        w_i2c_we    = 1'b0;

        if (w_stop) begin
            w_state_nx  = ST_IDLE;
            w_sda_oe_nx = 1'b0;
        end else if (w_start) begin
            w_state_nx  = ST_ADDR;
            w_bitcnt_nx = 4'd0;
            w_sda_oe_nx = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx  = w_byte;
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_bitcnt_nx = 4'd0;
                            if (r_state == ST_ADDR) begin
                                w_state_nx = (w_byte[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_WAIT;
                            end else if (r_state == ST_PTR) begin
                                w_ptr_nx   = w_byte[1:0];
                                w_state_nx = ST_PTR_ACK;
                            end else begin
                                w_i2c_we   = 1'b1;
                                w_ptr_nx   = r_ptr + 2'd1;
                                w_state_nx = ST_WACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nx = 1'b1;
                        end else if (r_state == ST_ADDR_ACK && r_shift[0]) begin
                            w_shift_nx  = r_regs[r_ptr];
                            w_sda_oe_nx = ~r_regs[r_ptr][7];
                            w_ptr_nx    = r_ptr + 2'd1;
                            w_bitcnt_nx = 4'd0;
                            w_state_nx  = ST_RDATA;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_bitcnt_nx = 4'd0;
                            w_state_nx  = (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_sda_oe_nx = 1'b0;
                            w_bitcnt_nx = 4'd0;
                            w_state_nx  = ST_RACK;
                        end else begin
                            w_sda_oe_nx = ~r_shift[6];
                            w_shift_nx  = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_RACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nx = ST_WAIT;
                        end
                    end else if (w_scl_fall) begin
                        w_shift_nx  = r_regs[r_ptr];
                        w_sda_oe_nx = ~r_regs[r_ptr][7];
                        w_ptr_nx    = r_ptr + 2'd1;
                        w_bitcnt_nx = 4'd0;
                        w_state_nx  = ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT: begin
                    w_sda_oe_nx = 1'b0;
                end
                default: begin
                    w_state_nx  = ST_IDLE;
                    w_sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    // I2C write is applied after the Avalon write so it wins a same-clk collision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_readdata <= 32'h0;
            r_irq      <= 1'b0;
        end else begin
            if (w_av_we) begin
                r_regs[address] <= writedata[7:0];
            end
            if (w_i2c_we) begin
                r_regs[r_ptr] <= w_byte;
            end
            r_readdata <= {24'h0, r_regs[address]};
            if (w_i2c_we) begin
                r_irq <= 1'b1;
            end else if (w_av_we) begin
                r_irq <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
